// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register: valid/ready handshake, 2-entry skid, flush and saturating stall counter.
// Optional delay-slot fields are carried when ID_EX_DELAYSLOT_EN is defined.
module id_ex_pipe #(
    parameter int unsigned AOP_W    = 8,
    parameter int unsigned ASEL_W   = 3,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RADDR_W  = 5,
    parameter int unsigned STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,

    input  logic                id_valid,
    output logic                id_ready,
    input  logic [AOP_W-1:0]    id_aluop,
    input  logic [ASEL_W-1:0]   id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [RADDR_W-1:0]  id_wd,
    input  logic                id_wreg,

    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [AOP_W-1:0]    ex_aluop,
    output logic [ASEL_W-1:0]   ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [RADDR_W-1:0]  ex_wd,
    output logic                ex_wreg,

`ifdef ID_EX_DELAYSLOT_EN
    input  logic                id_in_delayslot,
    input  logic [DATA_W-1:0]   id_link_addr,
    input  logic                id_next_in_delayslot,
    output logic                ex_in_delayslot,
    output logic [DATA_W-1:0]   ex_link_addr,
    output logic                ex_next_in_delayslot,
`endif

    output logic [STALL_CW-1:0] stall_cnt
);

    typedef struct packed {
        logic [AOP_W-1:0]   aluop;
        logic [ASEL_W-1:0]  alusel;
        logic [DATA_W-1:0]  reg1;
        logic [DATA_W-1:0]  reg2;
        logic [RADDR_W-1:0] wd;
        logic               wreg;
`ifdef ID_EX_DELAYSLOT_EN
        logic               in_delayslot;
        logic [DATA_W-1:0]  link_addr;
        logic               next_in_delayslot;
`endif
    } payload_t;

    // All-zero payload doubles as the NOP encoding (write disabled).
    localparam payload_t NopPayload = '0;

    typedef enum logic [1:0] {
        StEmpty,
        StFull,
        StSkid
    } state_e;

    state_e              state_q, state_d;
    payload_t            main_q, main_d;
    payload_t            skid_q, skid_d;
    logic                id_ready_q, id_ready_d;
    logic [STALL_CW-1:0] stall_q, stall_d;

    payload_t id_payload;
    logic     accept;
    logic     consume;
    logic     valid_out;

    always_comb begin
        id_payload        = NopPayload;
        id_payload.aluop  = id_aluop;
        id_payload.alusel = id_alusel;
        id_payload.reg1   = id_reg1;
        id_payload.reg2   = id_reg2;
        id_payload.wd     = id_wd;
        id_payload.wreg   = id_wreg;
`ifdef ID_EX_DELAYSLOT_EN
        id_payload.in_delayslot      = id_in_delayslot;
        id_payload.link_addr         = id_link_addr;
        id_payload.next_in_delayslot = id_next_in_delayslot;
`endif
    end

    assign valid_out = (state_q != StEmpty);
    assign accept    = id_valid & id_ready_q;
    assign consume   = valid_out & ex_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Squash wins over everything, including a same-cycle accept.
            state_d = StEmpty;
            main_d  = NopPayload;
            skid_d  = NopPayload;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = id_payload;
                        state_d = StFull;
                    end
                end
                StFull: begin
                    if (consume && accept) begin
                        main_d = id_payload;
                    end else if (consume) begin
                        main_d  = NopPayload;
                        state_d = StEmpty;
                    end else if (accept) begin
                        skid_d  = id_payload;
                        state_d = StSkid;
                    end
                end
                StSkid: begin
                    // id_ready is low here, so no accept can coincide with the drain.
                    if (consume) begin
                        main_d  = skid_q;
                        skid_d  = NopPayload;
                        state_d = StFull;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = NopPayload;
                    skid_d  = NopPayload;
                end
            endcase
        end

        id_ready_d = (state_d != StSkid);
    end

    always_comb begin
        stall_d = stall_q;
        if (valid_out && !ex_ready && (stall_q != {STALL_CW{1'b1}})) begin
            stall_d = stall_q + STALL_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            main_q     <= NopPayload;
            skid_q     <= NopPayload;
            id_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            id_ready_q <= id_ready_d;
            stall_q    <= stall_d;
        end
    end

    assign id_ready  = id_ready_q;
    assign ex_valid  = valid_out;
    assign ex_aluop  = main_q.aluop;
    assign ex_alusel = main_q.alusel;
    assign ex_reg1   = main_q.reg1;
    assign ex_reg2   = main_q.reg2;
    assign ex_wd     = main_q.wd;
    assign ex_wreg   = main_q.wreg;
    assign stall_cnt = stall_q;

`ifdef ID_EX_DELAYSLOT_EN
    assign ex_in_delayslot      = main_q.in_delayslot;
    assign ex_link_addr         = main_q.link_addr;
    assign ex_next_in_delayslot = main_q.next_in_delayslot;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios plus random traffic against a depth-2 FIFO model.
module tb_id_ex_pipe;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
`ifdef ID_EX_DELAYSLOT_EN
        logic        ds;
        logic [31:0] link;
        logic        nds;
`endif
    } pl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic id_valid = 1'b0;
    logic ex_ready = 1'b0;
    pl_t  in_pl = '0;

    logic        id_ready, ex_valid;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1, ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [15:0] stall_cnt;

    logic        s_id_ready, s_ex_valid;
    logic [7:0]  s_aluop;
    logic [2:0]  s_alusel;
    logic [31:0] s_reg1, s_reg2;
    logic [4:0]  s_wd;
    logic        s_wreg;
    logic [3:0]  s_stall_cnt;

`ifdef ID_EX_DELAYSLOT_EN
    logic        ex_ds, ex_nds, s_ds, s_nds;
    logic [31:0] ex_link, s_link;
`endif

    pl_t obs;
    always_comb begin
        obs        = '0;
        obs.aluop  = ex_aluop;
        obs.alusel = ex_alusel;
        obs.reg1   = ex_reg1;
        obs.reg2   = ex_reg2;
        obs.wd     = ex_wd;
        obs.wreg   = ex_wreg;
`ifdef ID_EX_DELAYSLOT_EN
        obs.ds   = ex_ds;
        obs.link = ex_link;
        obs.nds  = ex_nds;
`endif
    end

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_aluop(in_pl.aluop), .id_alusel(in_pl.alusel),
        .id_reg1(in_pl.reg1), .id_reg2(in_pl.reg2),
        .id_wd(in_pl.wd), .id_wreg(in_pl.wreg),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg),
`ifdef ID_EX_DELAYSLOT_EN
        .id_in_delayslot(in_pl.ds), .id_link_addr(in_pl.link),
        .id_next_in_delayslot(in_pl.nds),
        .ex_in_delayslot(ex_ds), .ex_link_addr(ex_link), .ex_next_in_delayslot(ex_nds),
`endif
        .stall_cnt(stall_cnt)
    );

    id_ex_pipe #(.STALL_CW(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(s_id_ready),
        .id_aluop(in_pl.aluop), .id_alusel(in_pl.alusel),
        .id_reg1(in_pl.reg1), .id_reg2(in_pl.reg2),
        .id_wd(in_pl.wd), .id_wreg(in_pl.wreg),
        .ex_valid(s_ex_valid), .ex_ready(ex_ready),
        .ex_aluop(s_aluop), .ex_alusel(s_alusel),
        .ex_reg1(s_reg1), .ex_reg2(s_reg2),
        .ex_wd(s_wd), .ex_wreg(s_wreg),
`ifdef ID_EX_DELAYSLOT_EN
        .id_in_delayslot(in_pl.ds), .id_link_addr(in_pl.link),
        .id_next_in_delayslot(in_pl.nds),
        .ex_in_delayslot(s_ds), .ex_link_addr(s_link), .ex_next_in_delayslot(s_nds),
`endif
        .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: a FIFO of at most two instructions; head is what EX sees.
    pl_t         mq[$];
    logic [15:0] m_stall = '0;
    logic [3:0]  m_stall4 = '0;

    function automatic pl_t exp_head();
        if (mq.size() != 0) return mq[0];
        return '0;
    endfunction

    function automatic pl_t rand_pl();
        pl_t p;
        p        = '0;
        p.aluop  = 8'($urandom);
        p.alusel = 3'($urandom);
        p.reg1   = $urandom;
        p.reg2   = $urandom;
        p.wd     = 5'($urandom);
        p.wreg   = 1'($urandom);
`ifdef ID_EX_DELAYSLOT_EN
        p.ds   = 1'($urandom);
        p.link = $urandom;
        p.nds  = 1'($urandom);
`endif
        return p;
    endfunction

    // Advance the model with the inputs in force, then clock and settle.
    task automatic tick();
        bit acc, cons;
        acc  = id_valid && (mq.size() < 2);
        cons = (mq.size() != 0) && ex_ready;
        if (mq.size() != 0 && !ex_ready) begin
            if (m_stall != 16'hFFFF) m_stall++;
            if (m_stall4 != 4'hF) m_stall4++;
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (cons) void'(mq.pop_front());
            if (acc) mq.push_back(in_pl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        in_pl = rand_pl();
        in_pl.wreg = 1'b1;
        id_valid = 1'b1;
        ex_ready = 1'b0;
        tick();
        id_valid = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        mq.delete();
        m_stall = '0;
        m_stall4 = '0;
        #1;
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid);
        end
        checks++;
        if (id_ready !== 1'b1) begin
            errors++; $display("FAIL reset_id_ready: got %b want 1", id_ready);
        end
        checks++;
        if (stall_cnt !== 16'h0 || s_stall_cnt !== 4'h0) begin
            errors++; $display("FAIL reset_stall: got %h/%h want 0", stall_cnt, s_stall_cnt);
        end
        checks++;
        if (obs !== pl_t'('0)) begin
            errors++; $display("FAIL reset_payload: got %h want 0", obs);
        end
        #1;
        rst = 1'b1;
    endtask

    task automatic test_streaming();
        ex_ready = 1'b1;
        id_valid = 1'b1;
        in_pl = rand_pl();
        in_pl.aluop = 8'h21;
        tick();
        checks++;
        if (ex_aluop !== 8'h21 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL stream_first: got op=%h v=%b want op=21 v=1", ex_aluop, ex_valid);
        end
        in_pl = rand_pl();
        in_pl.aluop = 8'h25;
        tick();
        checks++;
        if (ex_aluop !== 8'h25 || ex_valid !== 1'b1 || obs !== exp_head()) begin
            errors++; $display("FAIL stream_second: got %h want %h", obs, exp_head());
        end
        checks++;
        if (stall_cnt !== 16'h0) begin
            errors++; $display("FAIL stream_stall: got %0d want 0", stall_cnt);
        end
        id_valid = 1'b0;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || obs !== pl_t'('0)) begin
            errors++; $display("FAIL stream_drain: got v=%b pl=%h want v=0 pl=0", ex_valid, obs);
        end
    endtask

    task automatic test_skid();
        pl_t a, b, c;
        logic [15:0] s0;
        s0 = m_stall;
        a = rand_pl(); a.aluop = 8'hA1;
        b = rand_pl(); b.aluop = 8'hB2;
        c = rand_pl(); c.aluop = 8'hC3;
        ex_ready = 1'b1;
        id_valid = 1'b1;
        in_pl = a;
        tick();
        ex_ready = 1'b0;
        in_pl = b;
        tick();
        checks++;
        if (id_ready !== 1'b0 || obs !== a) begin
            errors++; $display("FAIL skid_enter: got rdy=%b op=%h want rdy=0 op=a1", id_ready, ex_aluop);
        end
        in_pl = c;
        tick();
        checks++;
        if (id_ready !== 1'b0 || obs !== a || ex_valid !== 1'b1) begin
            errors++; $display("FAIL skid_hold: got rdy=%b op=%h want rdy=0 op=a1", id_ready, ex_aluop);
        end
        ex_ready = 1'b1;
        id_valid = 1'b0;
        tick();
        checks++;
        if (obs !== b || ex_valid !== 1'b1 || id_ready !== 1'b1) begin
            errors++; $display("FAIL skid_drain_b: got op=%h rdy=%b want op=b2 rdy=1", ex_aluop, id_ready);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL skid_empty: got v=%b want 0", ex_valid);
        end
        checks++;
        if (stall_cnt !== s0 + 16'd2) begin
            errors++; $display("FAIL skid_stall: got %0d want %0d", stall_cnt, s0 + 16'd2);
        end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        in_pl = rand_pl(); in_pl.wreg = 1'b1; in_pl.wd = 5'h1F;
        tick();
        in_pl = rand_pl(); in_pl.wreg = 1'b1; in_pl.wd = 5'h11;
        tick();
        flush = 1'b1;
        in_pl = rand_pl(); in_pl.wreg = 1'b1; in_pl.wd = 5'h0A;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_wreg !== 1'b0 || ex_wd !== 5'h0 || id_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: got v=%b wreg=%b wd=%h rdy=%b want 0 0 00 1",
                     ex_valid, ex_wreg, ex_wd, id_ready);
        end
        flush = 1'b0;
        id_valid = 1'b0;
        ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ex_valid !== 1'b0 || obs !== pl_t'('0)) begin
                errors++; $display("FAIL flush_ghost: got v=%b pl=%h want v=0 pl=0", ex_valid, obs);
            end
        end
    endtask

    task automatic test_saturation();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        in_pl = rand_pl();
        tick();
        id_valid = 1'b0;
        repeat (20) tick();
        checks++;
        if (s_stall_cnt !== 4'hF || s_ex_valid !== 1'b1) begin
            errors++; $display("FAIL sat_cw4: got %h v=%b want f v=1", s_stall_cnt, s_ex_valid);
        end
        checks++;
        if (stall_cnt !== m_stall) begin
            errors++; $display("FAIL sat_cw16: got %0d want %0d", stall_cnt, m_stall);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (stall_cnt !== m_stall || s_stall_cnt !== 4'hF || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_flush: got %0d/%h v=%b want %0d/f v=0", stall_cnt, s_stall_cnt,
                     ex_valid, m_stall);
        end
    endtask

`ifdef ID_EX_DELAYSLOT_EN
    task automatic test_delayslot();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        in_pl = rand_pl();
        tick();
        in_pl = rand_pl();
        in_pl.link = 32'h0000_0408;
        tick();
        id_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        checks++;
        if (ex_link !== 32'h0000_0408 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL ds_link: got %h want 00000408", ex_link);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (ex_link !== 32'h0 || ex_ds !== 1'b0 || ex_nds !== 1'b0) begin
            errors++; $display("FAIL ds_flush: got %h %b %b want 0", ex_link, ex_ds, ex_nds);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            in_pl    = rand_pl();
            tick();
            checks++;
            if (ex_valid !== (mq.size() != 0) || id_ready !== (mq.size() < 2)) begin
                errors++;
                $display("FAIL rand_hs[%0d]: got v=%b rdy=%b want v=%b rdy=%b", i, ex_valid,
                         id_ready, mq.size() != 0, mq.size() < 2);
            end
            checks++;
            if (obs !== exp_head()) begin
                errors++; $display("FAIL rand_payload[%0d]: got %h want %h", i, obs, exp_head());
            end
            checks++;
            if (stall_cnt !== m_stall || s_stall_cnt !== m_stall4) begin
                errors++;
                $display("FAIL rand_stall[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt,
                         s_stall_cnt, m_stall, m_stall4);
            end
        end
        flush = 1'b0;
        id_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_saturation();
`ifdef ID_EX_DELAYSLOT_EN
        test_delayslot();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
